// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
//
// Shared definitions for the UART transmit arbiter:
//   - default parameter values for the requester count and guard length
//   - state encoding constants and the FSM state type
//   - width of the guard down-counter
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  // Default number of requesters sharing the UART (legal range 2..8).
  localparam int N_REQ_DEF = 4;

  // Default number of cycles after a strobe during which tx_busy is ignored
  // (legal range 1..15).
  localparam int GUARD_DEF = 2;

  // Guard counter width; holds values up to 15.
  localparam int GCNT_W = 4;

  // State encoding, also visible on the state_dbg output of the top.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_TX = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_GUARD   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_WAIT_TX = S_WAIT_TX,
    ST_ISSUE   = S_ISSUE,
    ST_GUARD   = S_GUARD
  } arb_state_e;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purely combinational round-robin picker. Searches the valid vector
// starting one position after `last`, wrapping modulo N_REQ, and returns the
// first set index. `last` itself is examined last, so a requester that was
// just served only wins again when nobody else is waiting.
//
// Ports:
//   valid [N_REQ]  in   per-requester pending flag
//   last  [IDW]    in   index served most recently
//   any            out  at least one valid bit is set
//   idx   [IDW]    out  winning index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   last,
  output logic             any,
  output logic [IDW-1:0]   idx
);

  // Candidate position for the current search step, kept as an int so the
  // wrap can be done with a plain compare/subtract for any N_REQ, including
  // non-powers of two.
  int             pos;
  logic [IDW-1:0] pos_idx;

  always_comb begin
    any     = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(last) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      pos_idx = IDW'(pos);
      // First hit wins; later hits are ignored once `any` is set.
      if (!any && valid[pos_idx]) begin
        any = 1'b1;
        idx = pos_idx;
      end
    end
  end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among N_REQ command handlers. Each handler
// owns a one-byte slot; the arbiter serves full slots round-robin and drives
// the UART strobe while honouring tx_busy.
//
// Handshake (requester side): a handler may pulse req_en[i] for one cycle
// whenever req_busy[i] is low; the byte on req_data[8i+7:8i] is captured on
// that edge and req_busy[i] reads high from the next cycle until the byte
// has been handed to the UART and its guard window has elapsed. A pulse
// while req_busy[i] is high is dropped and flagged in overflow[i], except in
// the release cycle itself, where the new byte simply replaces the sent one.
// Handshake (UART side): tx_en is a one-cycle strobe with tx_data valid; a
// new strobe is only issued after tx_busy has been seen low in WAIT_TX.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_en   [N]    one-cycle send pulse per requester
//   req_data [8N]   byte per requester, requester i on [8i+7:8i]
//   req_busy [N]    slot i holds an unsent byte
//   tx_data  [8]    byte to UART, stable from WAIT_TX entry to next grant
//   tx_en           one-cycle send strobe to UART (registered)
//   tx_busy         UART busy, sampled only in WAIT_TX
//   grant_id [IDW]  requester currently being served
//   overflow [N]    sticky per-requester drop flag, cleared only by reset
//   state_dbg[2]    current FSM state (S_IDLE/S_WAIT_TX/S_ISSUE/S_GUARD)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_en,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_busy,
  output logic [7:0]         tx_data,
  output logic               tx_en,
  input  logic               tx_busy,
  output logic [IDW-1:0]     grant_id,
  output logic [N_REQ-1:0]   overflow,
  output logic [1:0]         state_dbg
);

  // Value loaded into the guard counter on leaving ISSUE; the counter then
  // runs GUARD-1 .. 0, giving GUARD cycles in the GUARD state.
  localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD - 1);
  localparam logic [IDW-1:0]    LAST_RST   = IDW'(N_REQ - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0]      valid_q,  valid_d;
  logic [N_REQ-1:0][7:0] slot_q,   slot_d;
  logic [N_REQ-1:0]      ovf_q,    ovf_d;
  arb_state_e            state_q,  state_d;
  logic [IDW-1:0]        last_q,   last_d;
  logic [IDW-1:0]        grant_q,  grant_d;
  logic [7:0]            txd_q,    txd_d;
  logic                  tx_en_q,  tx_en_d;
  logic [GCNT_W-1:0]     cnt_q,    cnt_d;

  // Pulses in the last GUARD cycle to free slot grant_q.
  logic                  release_en;

  logic                  pick_any;
  logic [IDW-1:0]        pick_idx;

  // -------------------------------------------------------------------------
  // Round-robin selection over full slots
  // -------------------------------------------------------------------------
  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .valid (valid_q),
    .last  (last_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // -------------------------------------------------------------------------
  // FSM next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    txd_d      = txd_q;
    tx_en_d    = 1'b0;
    cnt_d      = cnt_q;
    release_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          txd_d   = slot_q[pick_idx];
          state_d = ST_WAIT_TX;
        end
      end

      ST_WAIT_TX: begin
        // tx_en is registered, so it is raised on the transition into ISSUE
        // and is high for exactly the ISSUE cycle.
        if (!tx_busy) begin
          tx_en_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        last_d  = grant_q;
        cnt_d   = GUARD_LOAD;
        state_d = ST_GUARD;
      end

      ST_GUARD: begin
        // tx_busy is deliberately not looked at here: the UART may take a
        // few cycles to raise it after our strobe.
        if (cnt_q == '0) begin
          release_en = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Slot capture, independent of the FSM
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_en[i]) begin
        // A slot being released this cycle counts as free, so a refill on
        // the release edge keeps valid set and is not an overflow.
        if (!valid_q[i] || (release_en && (grant_q == IDW'(i)))) begin
          valid_d[i] = 1'b1;
          slot_d[i]  = req_data[8*i +: 8];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end else if (release_en && (grant_q == IDW'(i))) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      slot_q  <= '0;
      ovf_q   <= '0;
      state_q <= ST_IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_busy  = valid_q;
  assign tx_data   = txd_q;
  assign tx_en     = tx_en_q;
  assign grant_id  = grant_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A transaction-level reference
// model (slot arrays, round-robin rule, strobe/release timestamps) runs on
// the clock and pushes each expected UART byte into exp_q; a monitor on the
// falling edge pops and compares whenever tx_en is seen, and also compares
// tx_en, req_busy and overflow every cycle. Directed scenarios add explicit
// checks of latency, ordering, spacing, overflow, fairness and async reset.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int G   = 2;
  localparam int IDW = 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic [N-1:0]     req_en   = '0;
  logic [8*N-1:0]   req_data = '0;
  logic             tx_busy  = 1'b0;
  logic [N-1:0]     req_busy;
  logic [7:0]       tx_data;
  logic             tx_en;
  logic [IDW-1:0]   grant_id;
  logic [N-1:0]     overflow;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ (N),
    .GUARD (G),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_en    (req_en),
    .req_data  (req_data),
    .req_busy  (req_busy),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // -------------------------------------------------------------------------
  int                 checks = 0;
  int                 errors = 0;
  logic [IDW+7:0]     exp_q[$];   // {grant_id, byte}
  int                 gid_log[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: one byte per requester, round-robin after `last`,
  // strobe two cycles after the grant at the earliest (first cycle after a
  // cycle in which the engine is waiting and tx_busy is low), slot freed
  // G cycles after the strobe, engine free again the cycle after that.
  // -------------------------------------------------------------------------
  bit          m_valid[N];
  logic [7:0]  m_data[N];
  logic [N-1:0] m_ovf      = '0;
  int          m_last      = N - 1;
  bit          eng_busy    = 1'b0;
  int          srv_id      = 0;
  logic [7:0]  srv_data    = '0;
  int          look_cyc    = 0;
  int          strobe_cyc  = -1;
  bit          m_tx_en     = 1'b0;
  int          ncyc        = 0;
  int          mc, mp, mrel_id;
  bit          mrel, m_nx;

  function automatic int rr_next(input int last);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (last + k) % N;
      if (m_valid[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_valid[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
      end
      m_ovf      = '0;
      m_last     = N - 1;
      eng_busy   = 1'b0;
      strobe_cyc = -1;
      m_tx_en    = 1'b0;
      exp_q.delete();
    end else begin
      mc      = ncyc;
      mrel    = 1'b0;
      mrel_id = srv_id;
      m_nx    = 1'b0;
      if (!eng_busy) begin
        mp = rr_next(m_last);
        if (mp >= 0) begin
          eng_busy   = 1'b1;
          srv_id     = mp;
          srv_data   = m_data[mp];
          look_cyc   = mc + 1;
          strobe_cyc = -1;
        end
      end else if (strobe_cyc < 0) begin
        if (mc >= look_cyc && tx_busy == 1'b0) begin
          strobe_cyc = mc + 1;
          m_nx       = 1'b1;
          m_last     = srv_id;
          exp_q.push_back({IDW'(srv_id), srv_data});
        end
      end else if (mc == strobe_cyc + G) begin
        mrel     = 1'b1;
        mrel_id  = srv_id;
        eng_busy = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_en[i]) begin
          if (!m_valid[i] || (mrel && mrel_id == i)) begin
            m_valid[i] = 1'b1;
            m_data[i]  = req_data[8*i +: 8];
          end else begin
            m_ovf[i] = 1'b1;
          end
        end else if (mrel && mrel_id == i) begin
          m_valid[i] = 1'b0;
        end
      end
      m_tx_en = m_nx;
      ncyc++;
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  logic [IDW+7:0] mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      check("tx_en", 32'(tx_en), 32'(m_tx_en));
      check("req_busy", 32'(req_busy), 32'(m_busy_vec()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (tx_en === 1'b1) begin
        gid_log.push_back(int'(grant_id));
        check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("strobe_data", 32'(tx_data), 32'(mon_e[7:0]));
          check("strobe_grant", 32'(grant_id), 32'(mon_e[IDW+7:8]));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic do_reset();
    req_en  = '0;
    tx_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_tx_en(input string name);
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 100), 32'd1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int         first_j, busy_cnt, nseen, cnt, guard_n, rep;
  int         fair_cnt[N];
  logic [7:0] sim_exp[4];

  initial begin
    sim_exp = '{8'h10, 8'h20, 8'h30, 8'h40};

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_req_busy", 32'(req_busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on requester 1
    req_en = 4'b0010;
    req_data[15:8] = 8'hA5;
    @(negedge clk);
    req_en = '0;
    first_j = -1;
    busy_cnt = 0;
    for (int j = 1; j <= 12; j++) begin
      if (tx_en === 1'b1 && first_j < 0) begin
        first_j = j;
        check("single_data", 32'(tx_data), 32'h A5);
        check("single_grant", 32'(grant_id), 32'd1);
      end
      if (req_busy[1]) busy_cnt++;
      @(negedge clk);
    end
    check("single_latency", 32'(first_j), 32'd3);
    check("single_busy_cycles", 32'(busy_cnt), 32'(3 + G));

    // Simultaneous requests from all four, last starts at 3
    do_reset();
    req_en   = 4'b1111;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    @(negedge clk);
    req_en = '0;
    nseen  = 0;
    for (int j = 1; j <= 25; j++) begin
      if (tx_en === 1'b1 && nseen < 4) begin
        check("sim_data", 32'(tx_data), 32'(sim_exp[nseen]));
        check("sim_spacing", 32'(j), 32'(3 + (3 + G) * nseen));
        nseen++;
      end
      @(negedge clk);
    end
    check("sim_count", 32'(nseen), 32'd4);

    // UART busy holds the arbiter in WAIT_TX
    do_reset();
    tx_busy = 1'b1;
    req_en  = 4'b0100;
    req_data[23:16] = 8'h3C;
    @(negedge clk);
    req_en = '0;
    cnt = 0;
    repeat (20) begin
      if (tx_en === 1'b1) cnt++;
      @(negedge clk);
    end
    check("hold_no_strobe", 32'(cnt), 32'd0);
    check("hold_state", 32'(state_dbg), 32'(S_WAIT_TX));
    tx_busy = 1'b0;
    @(negedge clk);
    check("hold_release_strobe", 32'(tx_en), 32'd1);
    check("hold_data", 32'(tx_data), 32'h3C);
    check("hold_grant", 32'(grant_id), 32'd2);

    // Overflow, then refill on the exact release cycle
    do_reset();
    tx_busy = 1'b1;
    req_en  = 4'b0001;
    req_data[7:0] = 8'h11;
    @(negedge clk);
    req_data[7:0] = 8'h22;
    @(negedge clk);
    req_en = '0;
    check("ovf_set", 32'(overflow), 32'h1);
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    wait_tx_en("ovf_first");
    check("ovf_first_data", 32'(tx_data), 32'h11);
    repeat (G) @(negedge clk);
    req_en = 4'b0001;
    req_data[7:0] = 8'h33;
    @(negedge clk);
    req_en = '0;
    check("refill_busy", 32'(req_busy[0]), 32'd1);
    wait_tx_en("refill");
    check("refill_data", 32'(tx_data), 32'h33);
    check("refill_ovf", 32'(overflow), 32'h1);
    repeat (8) @(negedge clk);

    // Fairness: refill every slot as soon as it frees up
    do_reset();
    gid_log.delete();
    guard_n = 0;
    while (gid_log.size() < 40 && guard_n < 1000) begin
      for (int i = 0; i < N; i++) begin
        req_en[i] = !req_busy[i];
        req_data[8*i +: 8] = 8'($urandom);
      end
      @(negedge clk);
      guard_n++;
    end
    req_en = '0;
    check("fair_timeout", 32'(gid_log.size() >= 40), 32'd1);
    for (int i = 0; i < N; i++) fair_cnt[i] = 0;
    rep = 0;
    for (int k = 0; k < 40 && k < gid_log.size(); k++) begin
      fair_cnt[gid_log[k]]++;
      if (k > 0 && gid_log[k] == gid_log[k-1]) rep++;
    end
    for (int i = 0; i < N; i++) check("fair_count", 32'(fair_cnt[i]), 32'd10);
    check("fair_no_repeat", 32'(rep), 32'd0);
    repeat (30) @(negedge clk);

    // Random traffic against the model
    do_reset();
    repeat (800) begin
      for (int i = 0; i < N; i++) req_en[i] = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      tx_busy  = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    req_en  = '0;
    tx_busy = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset during ISSUE
    do_reset();
    tx_busy = 1'b1;
    req_en  = 4'b0100;
    req_data[23:16] = 8'h55;
    @(negedge clk);
    req_data[23:16] = 8'h66;
    @(negedge clk);
    req_en = '0;
    check("pre_rst_ovf", 32'(overflow[2]), 32'd1);
    tx_busy = 1'b0;
    wait_tx_en("rst_issue");
    check("rst_in_issue", 32'(state_dbg), 32'(S_ISSUE));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tx_en", 32'(tx_en), 32'd0);
    check("async_req_busy", 32'(req_busy), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_en === 1'b1) cnt++;
    end
    check("post_rst_quiet", 32'(cnt), 32'd0);

    repeat (5) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_tx_arbiter
